// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter that shares one data-memory port among per-core cache controllers.
// One owner is granted and holds the port for MEM_LATENCY cycles; priority rotates on completion.
module dmem_rr_arbiter #(
  parameter int NUM_CORES   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_gnt,
  output logic [NUM_CORES-1:0]          core_done,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                 state_r;
  logic [IDX_W-1:0]       owner_r;
  logic [IDX_W-1:0]       rr_ptr_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [NUM_CORES-1:0]   gnt_r;
  logic [NUM_CORES-1:0]   done_r;
  logic [DATA_W-1:0]      rdata_r;
  logic                   mem_en_r;
  logic                   mem_we_r;
  logic [ADDR_W-1:0]      mem_addr_r;
  logic [DATA_W-1:0]      mem_wdata_r;

  logic                   found_s;
  logic [IDX_W-1:0]       winner_s;
  logic [IDX_W-1:0]       cand_s;

  // (base + off) mod NUM_CORES, valid for base < NUM_CORES and off <= NUM_CORES
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W:0]   off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= (IDX_W+1)'(NUM_CORES)) begin
      sum = sum - (IDX_W+1)'(NUM_CORES);
    end else begin
      sum = sum;
    end
    return IDX_W'(sum);
  endfunction

  // Circular scan starting at rr_ptr: first requesting core wins
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_s = wrap_add(rr_ptr_r, (IDX_W+1)'(k));
      if (!found_s && core_req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Arbitration FSM with registered grant/done pulses and memory command
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      rr_ptr_r    <= '0;
      cnt_r       <= '0;
      gnt_r       <= '0;
      done_r      <= '0;
      rdata_r     <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      gnt_r  <= '0;
      done_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r         <= ST_ACCESS;
            owner_r         <= winner_s;
            cnt_r           <= CNT_W'(MEM_LATENCY - 1);
            gnt_r[winner_s] <= 1'b1;
            mem_en_r        <= 1'b1;
            mem_we_r        <= core_we[winner_s];
            mem_addr_r      <= core_addr[int'(winner_s)*ADDR_W +: ADDR_W];
            mem_wdata_r     <= core_wdata[int'(winner_s)*DATA_W +: DATA_W];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_r != CNT_W'(0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            // Completion: rotate priority past the finishing owner
            state_r         <= ST_IDLE;
            done_r[owner_r] <= 1'b1;
            rr_ptr_r        <= wrap_add(owner_r, (IDX_W+1)'(1));
            if (!mem_we_r) begin
              rdata_r <= mem_rdata;
            end else begin
              rdata_r <= rdata_r;
            end
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_en_r    <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_addr_r  <= '0;
          mem_wdata_r <= '0;
        end
      endcase
    end
  end

  assign core_gnt   = gnt_r;
  assign core_done  = done_r;
  assign core_rdata = rdata_r;
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = (state_r == ST_ACCESS);

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Self-checking bench for dmem_rr_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     core_req = '0;
  logic [N-1:0]     core_we = '0;
  logic [N*AW-1:0]  core_addr = '0;
  logic [N*DW-1:0]  core_wdata = '0;
  logic [N-1:0]     core_gnt;
  logic [N-1:0]     core_done;
  logic [DW-1:0]    core_rdata;
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata = '0;
  logic             busy;

  dmem_rr_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_done(core_done), .core_rdata(core_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a transaction occupies cycles m_start .. m_start+L-1
  int            cyc = 0;
  bit            m_active = 0;
  int            m_owner = 0;
  int            m_start = 0;
  int            m_rr = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [N-1:0]  e_gnt = '0;
  logic [N-1:0]  e_done = '0;
  logic [DW-1:0] e_rdata = '0;

  int wait_cnt [N];
  int max_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit got;
    int idx;
    e_gnt  = '0;
    e_done = '0;
    got    = 0;
    if (reset) begin
      m_active = 0;
      m_rr     = 0;
      e_rdata  = '0;
    end else if (m_active) begin
      if (cyc == m_start + L - 1) begin
        m_active        = 0;
        e_done[m_owner] = 1'b1;
        m_rr            = (m_owner + 1) % N;
        if (!m_we) e_rdata = mem_rdata;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!got && core_req[idx]) begin
          got        = 1;
          m_active   = 1;
          m_owner    = idx;
          m_start    = cyc + 1;
          m_we       = core_we[idx];
          m_addr     = core_addr[idx*AW +: AW];
          m_wdata    = core_wdata[idx*DW +: DW];
          e_gnt[idx] = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare();
    chk("core_gnt",   64'(core_gnt),   64'(e_gnt));
    chk("core_done",  64'(core_done),  64'(e_done));
    chk("core_rdata", 64'(core_rdata), 64'(e_rdata));
    chk("mem_en",     64'(mem_en),     64'(m_active));
    chk("busy",       64'(busy),       64'(m_active));
    chk("mem_we",     64'(mem_we),     m_active ? 64'(m_we) : 64'd0);
    chk("mem_addr",   64'(mem_addr),   m_active ? 64'(m_addr) : 64'd0);
    chk("mem_wdata",  64'(mem_wdata),  m_active ? 64'(m_wdata) : 64'd0);
    for (int i = 0; i < N; i++) begin
      if (reset || e_gnt[i] || !core_req[i]) wait_cnt[i] = 0;
      else wait_cnt[i]++;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  // One clock: DUT and model both take the edge, outputs checked at negedge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    core_req = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic new_cmd(input int i);
    core_we[i]             = 1'($urandom_range(0, 1));
    core_addr[i*AW +: AW]  = $urandom;
    core_wdata[i*DW +: DW] = $urandom;
  endtask

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    @(negedge clk);
    do_reset();
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_rdata", 64'(core_rdata), 64'd0);

    // Single read by core0
    core_req = 2'b01; core_we[0] = 1'b0; core_addr[31:0] = 32'h10;
    mem_rdata = 32'hDEADBEEF;
    cycle();
    chk("rd_gnt_c1", 64'(core_gnt), 64'h1);
    chk("rd_en_c1", 64'(mem_en), 64'h1);
    chk("rd_addr_c1", 64'(mem_addr), 64'h10);
    core_req = 2'b00;
    cycle();
    chk("rd_en_c2", 64'(mem_en), 64'h1);
    chk("rd_addr_c2", 64'(mem_addr), 64'h10);
    cycle();
    chk("rd_done_c3", 64'(core_done), 64'h1);
    chk("rd_rdata_c3", 64'(core_rdata), 64'hDEADBEEF);

    // Write by core1: rdata must keep the earlier read value
    core_req = 2'b10; core_we[1] = 1'b1; core_addr[63:32] = 32'h24;
    core_wdata[63:32] = 32'h55; mem_rdata = 32'h12345678;
    cycle();
    chk("wr_gnt_c1", 64'(core_gnt), 64'h2);
    chk("wr_we_c1", 64'(mem_we), 64'h1);
    chk("wr_wdata_c1", 64'(mem_wdata), 64'h55);
    core_req = 2'b00;
    cycle();
    chk("wr_we_c2", 64'(mem_we), 64'h1);
    chk("wr_wdata_c2", 64'(mem_wdata), 64'h55);
    cycle();
    chk("wr_done_c3", 64'(core_done), 64'h2);
    chk("wr_rdata_c3", 64'(core_rdata), 64'hDEADBEEF);

    // Both cores requesting continuously from reset: alternate every 3 cycles
    do_reset();
    core_req = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      chk("alt_gnt", 64'(core_gnt),
          (i % 3 == 1) ? (((i / 3) % 2 == 0) ? 64'h1 : 64'h2) : 64'h0);
    end

    // Single persistent requester
    do_reset();
    core_req = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      chk("solo_gnt", 64'(core_gnt), (i % 3 == 1) ? 64'h1 : 64'h0);
    end

    // Starvation: core1 arrives during core0's access, core0 re-requests
    do_reset();
    core_req = 2'b01;
    cycle();
    chk("stv_gnt0", 64'(core_gnt), 64'h1);
    core_req = 2'b11;
    cycle();
    cycle();
    chk("stv_done0", 64'(core_done), 64'h1);
    cycle();
    chk("stv_gnt1", 64'(core_gnt), 64'h2);
    core_req = 2'b01;
    cycle();
    cycle();
    core_req = 2'b00;
    cycle();

    // Reset in second access cycle after rr_ptr has moved to 1
    do_reset();
    core_req = 2'b01;
    cycle();
    core_req = 2'b00;
    cycle();
    cycle();
    core_req = 2'b01;
    cycle();
    chk("mr_gnt0", 64'(core_gnt), 64'h1);
    core_req = 2'b00;
    cycle();
    reset = 1'b1;
    cycle();
    chk("mr_done", 64'(core_done), 64'h0);
    chk("mr_en", 64'(mem_en), 64'h0);
    chk("mr_busy", 64'(busy), 64'h0);
    reset = 1'b0;
    core_req = 2'b11;
    cycle();
    chk("mr_gnt_after", 64'(core_gnt), 64'h1);
    core_req = 2'b10;

    // Randomized traffic obeying the request protocol
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (core_req[i] && core_gnt[i]) begin
          if ($urandom_range(0, 1) == 1) core_req[i] = 1'b0;
          else new_cmd(i);
        end else if (!core_req[i] && $urandom_range(0, 2) == 0) begin
          core_req[i] = 1'b1;
          new_cmd(i);
        end
      end
      mem_rdata = $urandom;
      cycle();
    end
    reset = 1'b0;
    chk("max_wait_bound", 64'(max_wait <= N * (L + 1) + 2), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
